// File: rtl/pwm_cmd_parser.sv
// pwm_cmd_parser: parses ASCII D/A/B commands into pwm_core duty/pow2/pow5.
// Define PWM_CMD_ACK_EN to enable the 'K'/'E' acknowledge channel.
module pwm_cmd_parser #(
  parameter int unsigned DUTY_RESET     = 50,
  parameter int unsigned POW2_RESET     = 0,
  parameter int unsigned POW5_RESET     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [6:0] duty_percent,
  output logic [1:0] pow2,
  output logic [1:0] pow5,
  output logic       cfg_update,
  output logic       cmd_error,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DUTY,
    P2,
    P5,
    FLUSH
  } state_t;

  state_t        state;
  logic [6:0]    acc;
  logic [1:0]    ndig;
  logic [TW-1:0] cnt;
  logic          hold;

  logic [7:0] lc;
  logic [3:0] digit;
  logic       is_term;
  logic       is_space;
  logic       is_digit;
  logic       take;

  // Setting bit 5 folds upper-case letters onto lower-case.
  assign lc       = rx_data | 8'h20;
  assign digit    = rx_data[3:0];
  assign is_term  = (rx_data == 8'h0d) || (rx_data == 8'h0a);
  assign is_space = (rx_data == 8'h20);
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign take     = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      acc          <= '0;
      ndig         <= '0;
      cnt          <= '0;
      duty_percent <= 7'(DUTY_RESET);
      pow2         <= 2'(POW2_RESET);
      pow5         <= 2'(POW5_RESET);
      cfg_update   <= 1'b0;
      cmd_error    <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      cmd_error  <= 1'b0;
      if (take) begin
        cnt <= '0;
        unique case (state)
          IDLE: begin
            acc  <= '0;
            ndig <= '0;
            unique case (1'b1)
              lc == 8'h64:         state <= DUTY;
              lc == 8'h61:         state <= P2;
              lc == 8'h62:         state <= P5;
              is_term || is_space: state <= IDLE;
              default:             cmd_error <= 1'b1;
            endcase
          end
          DUTY: begin
            if (is_term) begin
              state <= IDLE;
              if (ndig == 2'd0) begin
                cmd_error <= 1'b1;
              end else begin
                duty_percent <= acc;
                cfg_update   <= 1'b1;
              end
            end else if (is_digit && ndig != 2'd2) begin
              acc  <= acc * 7'd10 + 7'(digit);
              ndig <= ndig + 2'd1;
            end else begin
              state <= FLUSH;
            end
          end
          P2, P5: begin
            if (is_term) begin
              state <= IDLE;
              if (ndig == 2'd0) begin
                cmd_error <= 1'b1;
              end else begin
                if (state == P2) pow2 <= acc[1:0];
                else pow5 <= acc[1:0];
                cfg_update <= 1'b1;
              end
            end else if (is_digit && ndig == 2'd0 && digit <= 4'd3) begin
              acc  <= 7'(digit);
              ndig <= 2'd1;
            end else begin
              state <= FLUSH;
            end
          end
          FLUSH: begin
            if (is_term) begin
              state     <= IDLE;
              cmd_error <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && !hold) begin
        if (cnt == TLAST) begin
          state     <= IDLE;
          cmd_error <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef PWM_CMD_ACK_EN
  logic pulse;
  logic tx_busy;
  logic ack_k;

  // The pulse cycle itself presents the ack; tx_busy keeps it until taken.
  assign pulse = cfg_update | cmd_error;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_busy <= 1'b0;
      ack_k   <= 1'b0;
    end else begin
      tx_busy <= tx_valid && !tx_ready;
      if (pulse) ack_k <= cfg_update;
    end
  end

  assign tx_valid = pulse | tx_busy;
  assign tx_data  = !tx_valid ? 8'h00 :
                    (pulse ? cfg_update : ack_k) ? 8'h4b : 8'h45;
  assign rx_ready = !tx_valid;
  assign hold     = tx_valid;
`else
  logic unused_tx_ready;

  assign unused_tx_ready = tx_ready;
  assign tx_valid        = 1'b0;
  assign tx_data         = 8'h00;
  assign rx_ready        = 1'b1;
  assign hold            = 1'b0;
`endif

endmodule
